// File: rtl/mem_stream_pkg.sv
// Shared types for the stream memory responder: read FSM states, default width,
// and the byte-strobe masking helper.
package mem_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int MAX_DATA_WIDTH     = 256;
  localparam int MAX_STRB_WIDTH     = MAX_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_SEND  = 2'd2
  } rd_state_e;

  // Callers zero-extend into the max width and truncate the result back.
  function automatic logic [MAX_DATA_WIDTH-1:0] strb_mask(
    input logic [MAX_DATA_WIDTH-1:0] data,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_ram.sv
// Simple dual-port RAM: one write port, one read port, 1-cycle registered read.
// Read data holds while i_re is low; contents are never reset.
module stream_ram
  import mem_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stream_mem_responder.sv
// Circular word buffer filled from a strobed AXI-Stream slave and drained as one packet on rd_req.
// First read beat 2 cycles after rd_req, then 1 beat/cycle; output held while m01_axis_tready is low.
module stream_mem_responder
  import mem_stream_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  axis_aclk,
  input  logic                  axis_areset,
  input  logic [DATA_WIDTH-1:0] s01_axis_tdata,
  input  logic [STRB_WIDTH-1:0] s01_axis_tstrb,
  input  logic                  s01_axis_tvalid,
  input  logic                  s01_axis_tlast,
  output logic                  s01_axis_tready,
  input  logic                  rd_req,
  input  logic                  m01_axis_tready,
  output logic [DATA_WIDTH-1:0] m01_axis_tdata,
  output logic [STRB_WIDTH-1:0] m01_axis_tstrb,
  output logic                  m01_axis_tvalid,
  output logic                  m01_axis_tlast,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  rd_busy,
  output logic                  rd_empty_err,
  output logic [7:0]            wr_pkts
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

  rd_state_e              r_state, w_next_state;
  logic [ADDR_WIDTH-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_WIDTH-1:0]   r_count, w_count_next;
  logic [CNT_WIDTH-1:0]   r_beats;
  logic                   r_s_tready;
  logic                   r_err;
  logic [7:0]             r_wr_pkts;
  logic                   w_wr_acc, w_beat_done, w_start;
  logic                   w_ram_re;
  logic [ADDR_WIDTH-1:0]  w_ram_raddr;
  logic [DATA_WIDTH-1:0]  w_wr_dat, w_ram_rdata;

  assign w_wr_acc    = s01_axis_tvalid && r_s_tready;
  assign w_beat_done = (r_state == R_SEND) && m01_axis_tready;
  assign w_start     = (r_state == R_IDLE) && rd_req && (r_count != '0);
  assign w_wr_dat    = DATA_WIDTH'(strb_mask(MAX_DATA_WIDTH'(s01_axis_tdata),
                                             MAX_STRB_WIDTH'(s01_axis_tstrb)));

  always_comb begin
    w_count_next = r_count;
    if (w_wr_acc && !w_beat_done)      w_count_next = r_count + CNT_WIDTH'(1);
    else if (!w_wr_acc && w_beat_done) w_count_next = r_count - CNT_WIDTH'(1);
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) r_state <= R_IDLE;
    else             r_state <= w_next_state;
  end

  // RAM output register doubles as the output data stage: it only advances on a completed beat.
  always_comb begin
    w_next_state = r_state;
    w_ram_re     = 1'b0;
    w_ram_raddr  = r_rd_ptr;
    case (r_state)
      R_IDLE: if (w_start) w_next_state = R_FETCH;
      R_FETCH: begin
        w_ram_re     = 1'b1;
        w_next_state = R_SEND;
      end
      R_SEND: begin
        if (w_beat_done) begin
          if (r_beats == CNT_WIDTH'(1)) begin
            w_next_state = R_IDLE;
          end else begin
            w_ram_re    = 1'b1;
            w_ram_raddr = r_rd_ptr + ADDR_WIDTH'(1);
          end
        end
      end
      default: w_next_state = R_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_beats    <= '0;
      r_s_tready <= 1'b0;
      r_err      <= 1'b0;
      r_wr_pkts  <= '0;
    end else begin
      r_s_tready <= (w_count_next != DEPTH_CNT);
      r_count    <= w_count_next;
      r_err      <= (r_state == R_IDLE) && rd_req && (r_count == '0);
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_beat_done) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      if (w_wr_acc && s01_axis_tlast) r_wr_pkts <= r_wr_pkts + 8'd1;
      if (w_start)          r_beats <= r_count;
      else if (w_beat_done) r_beats <= r_beats - CNT_WIDTH'(1);
    end
  end

  stream_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (axis_aclk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_dat),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  assign s01_axis_tready = r_s_tready;
  assign m01_axis_tvalid = (r_state == R_SEND);
  assign m01_axis_tdata  = m01_axis_tvalid ? w_ram_rdata : '0;
  assign m01_axis_tstrb  = m01_axis_tvalid ? '1 : '0;
  assign m01_axis_tlast  = m01_axis_tvalid && (r_beats == CNT_WIDTH'(1));
  assign count           = r_count;
  assign full            = (r_count == DEPTH_CNT);
  assign empty           = (r_count == '0);
  assign rd_busy         = (r_state != R_IDLE);
  assign rd_empty_err    = r_err;
  assign wr_pkts         = r_wr_pkts;

endmodule

// File: tb/tb_stream_mem_responder.sv
// Self-checking bench: directed sequences, a strobe table, and randomized traffic against a queue model.
module tb_stream_mem_responder;

  localparam int DW = 32;
  localparam int DP = 16;

  logic        axis_aclk = 1'b0;
  logic        axis_areset;
  logic [31:0] s01_axis_tdata;
  logic [3:0]  s01_axis_tstrb;
  logic        s01_axis_tvalid;
  logic        s01_axis_tlast;
  logic        s01_axis_tready;
  logic        rd_req;
  logic        m01_axis_tready;
  logic [31:0] m01_axis_tdata;
  logic [3:0]  m01_axis_tstrb;
  logic        m01_axis_tvalid;
  logic        m01_axis_tlast;
  logic [4:0]  count;
  logic        full, empty, rd_busy, rd_empty_err;
  logic [7:0]  wr_pkts;

  stream_mem_responder #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .axis_aclk       (axis_aclk),
    .axis_areset     (axis_areset),
    .s01_axis_tdata  (s01_axis_tdata),
    .s01_axis_tstrb  (s01_axis_tstrb),
    .s01_axis_tvalid (s01_axis_tvalid),
    .s01_axis_tlast  (s01_axis_tlast),
    .s01_axis_tready (s01_axis_tready),
    .rd_req          (rd_req),
    .m01_axis_tready (m01_axis_tready),
    .m01_axis_tdata  (m01_axis_tdata),
    .m01_axis_tstrb  (m01_axis_tstrb),
    .m01_axis_tvalid (m01_axis_tvalid),
    .m01_axis_tlast  (m01_axis_tlast),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .rd_busy         (rd_busy),
    .rd_empty_err    (rd_empty_err),
    .wr_pkts         (wr_pkts)
  );

  always #5 axis_aclk = ~axis_aclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge axis_aclk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mask32(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Reference model: stored words in arrival order, plus packet bookkeeping.
  logic [31:0] m_q[$];
  bit          m_busy = 0;
  int          pkt_left = 0;
  bit          m_err_pend = 0;
  logic [7:0]  m_pkts = '0;
  bit          held_vld = 0;
  logic [31:0] held_dat;
  logic        held_last;
  bit          mon_on = 0;
  logic [31:0] obs_dat[$];
  logic        obs_last[$];
  int          obs_cyc[$];

  always @(negedge axis_aclk) begin
    if (mon_on) begin
      bit was_busy;
      was_busy = m_busy;
      chk("count", 64'(count), 64'(m_q.size()));
      chk("s_tready", 64'(s01_axis_tready), 64'(m_q.size() != DP));
      chk("full", 64'(full), 64'(m_q.size() == DP));
      chk("empty", 64'(empty), 64'(m_q.size() == 0));
      chk("rd_busy", 64'(rd_busy), 64'(m_busy));
      chk("rd_empty_err", 64'(rd_empty_err), 64'(m_err_pend));
      chk("wr_pkts", 64'(wr_pkts), 64'(m_pkts));
      m_err_pend = 0;
      if (held_vld) begin
        chk("stall_vld", 64'(m01_axis_tvalid), 64'(1));
        chk("stall_dat", 64'(m01_axis_tdata), 64'(held_dat));
        chk("stall_last", 64'(m01_axis_tlast), 64'(held_last));
      end
      held_vld = 0;
      if (!m_busy) chk("idle_vld", 64'(m01_axis_tvalid), 64'(0));
      if (!m01_axis_tvalid) begin
        chk("idle_out", {m01_axis_tdata, 27'd0, m01_axis_tstrb, m01_axis_tlast}, 64'(0));
      end else begin
        chk("m_tstrb", 64'(m01_axis_tstrb), 64'hF);
        if (m01_axis_tready && m_q.size() > 0 && m_busy) begin
          chk("beat_dat", 64'(m01_axis_tdata), 64'(m_q.pop_front()));
          chk("beat_last", 64'(m01_axis_tlast), 64'(pkt_left == 1));
          obs_dat.push_back(m01_axis_tdata);
          obs_last.push_back(m01_axis_tlast);
          obs_cyc.push_back(cyc);
          pkt_left--;
          if (pkt_left == 0) m_busy = 0;
        end else if (!m01_axis_tready) begin
          held_vld  = 1;
          held_dat  = m01_axis_tdata;
          held_last = m01_axis_tlast;
        end
      end
      if (rd_req && !was_busy) begin
        if (m_q.size() > 0) begin
          m_busy   = 1;
          pkt_left = m_q.size();
        end else begin
          m_err_pend = 1;
        end
      end
      if (s01_axis_tvalid && s01_axis_tready) begin
        m_q.push_back(mask32(s01_axis_tdata, s01_axis_tstrb));
        if (s01_axis_tlast) m_pkts = m_pkts + 8'd1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge axis_aclk);
      #1;
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_busy = 0; pkt_left = 0; m_err_pend = 0; m_pkts = '0; held_vld = 0;
  endtask

  task automatic obs_clear();
    obs_dat.delete(); obs_last.delete(); obs_cyc.delete();
  endtask

  task automatic wr(input logic [31:0] d, input logic [3:0] s, input logic l);
    bit acc;
    int g;
    acc = 0; g = 0;
    s01_axis_tdata = d; s01_axis_tstrb = s; s01_axis_tlast = l; s01_axis_tvalid = 1;
    while (!acc && g < 100) begin
      @(negedge axis_aclk);
      acc = s01_axis_tready;
      @(posedge axis_aclk);
      #1;
      g++;
    end
    s01_axis_tvalid = 0;
    chk("wr_accept", 64'(acc), 64'(1));
  endtask

  task automatic rd_pulse();
    rd_req = 1;
    step(1);
    rd_req = 0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((rd_busy || m01_axis_tvalid) && g < 300) begin
      step(1);
      g++;
    end
    chk("wait_idle", 64'(rd_busy), 64'(0));
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        tbl[6];
    logic [31:0] exp4[4];
    bit          acc;
    int          g;
    logic        pat[12];

    axis_areset = 1; s01_axis_tdata = '0; s01_axis_tstrb = '0; s01_axis_tvalid = 0;
    s01_axis_tlast = 0; rd_req = 0; m01_axis_tready = 0;

    // Reset state and release
    step(3);
    chk("rst_s_tready", 64'(s01_axis_tready), 64'(0));
    chk("rst_m_out", {m01_axis_tdata, 26'd0, m01_axis_tstrb, m01_axis_tvalid, m01_axis_tlast}, 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_flags", {60'd0, empty, full, rd_busy, rd_empty_err}, 64'b1000);
    chk("rst_wr_pkts", 64'(wr_pkts), 64'(0));
    axis_areset = 0;
    step(1);
    chk("rel_s_tready", 64'(s01_axis_tready), 64'(1));
    chk("rel_empty", 64'(empty), 64'(1));
    model_clear();
    mon_on = 1;

    // Basic 4-word write and readout with latency and back-to-back beats
    obs_clear();
    m01_axis_tready = 1;
    wr(32'h11, 4'hF, 0); wr(32'h22, 4'hF, 0); wr(32'h33, 4'hF, 0); wr(32'h44, 4'hF, 1);
    rd_req = 1;
    step(1);
    rd_req = 0;
    chk("lat_c1_vld", 64'(m01_axis_tvalid), 64'(0));
    chk("lat_c1_busy", 64'(rd_busy), 64'(1));
    step(1);
    chk("lat_c2_vld", 64'(m01_axis_tvalid), 64'(1));
    chk("lat_c2_dat", 64'(m01_axis_tdata), 64'h11);
    wait_idle();
    exp4[0] = 32'h11; exp4[1] = 32'h22; exp4[2] = 32'h33; exp4[3] = 32'h44;
    chk("basic_nbeats", 64'(obs_dat.size()), 64'(4));
    for (int i = 0; i < 4 && i < obs_dat.size(); i++) begin
      chk("basic_dat", 64'(obs_dat[i]), 64'(exp4[i]));
      chk("basic_last", 64'(obs_last[i]), 64'(i == 3));
      chk("basic_b2b", 64'(obs_cyc[i] - obs_cyc[0]), 64'(i));
    end
    chk("basic_wr_pkts", 64'(wr_pkts), 64'(1));
    chk("basic_count", 64'(count), 64'(0));

    // Fill to DEPTH, hold a 17th beat, accept it once a slot frees; readout crosses pointer wrap
    for (int i = 0; i < DP; i++) wr(32'h100 + i, 4'hF, i == DP - 1);
    chk("full_flag", 64'(full), 64'(1));
    chk("full_s_tready", 64'(s01_axis_tready), 64'(0));
    s01_axis_tdata = 32'h5A5A0017; s01_axis_tstrb = 4'hF; s01_axis_tlast = 1; s01_axis_tvalid = 1;
    step(4);
    chk("full_hold_count", 64'(count), 64'(DP));
    obs_clear();
    rd_req = 1;
    step(1);
    rd_req = 0;
    acc = 0; g = 0;
    while (!acc && g < 60) begin
      @(negedge axis_aclk);
      acc = s01_axis_tready;
      @(posedge axis_aclk);
      #1;
      g++;
    end
    s01_axis_tvalid = 0;
    chk("beat17_accept", 64'(acc), 64'(1));
    wait_idle();
    chk("full_nbeats", 64'(obs_dat.size()), 64'(DP));
    for (int i = 0; i < DP && i < obs_dat.size(); i++)
      chk("full_dat", 64'(obs_dat[i]), 64'(32'h100 + i));
    chk("after_full_count", 64'(count), 64'(1));
    obs_clear();
    rd_pulse();
    wait_idle();
    chk("b17_nbeats", 64'(obs_dat.size()), 64'(1));
    if (obs_dat.size() > 0) begin
      chk("b17_dat", 64'(obs_dat[0]), 64'h5A5A0017);
      chk("b17_last", 64'(obs_last[0]), 64'(1));
    end

    // Stall pattern on m01_axis_tready
    pat = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0};
    for (int i = 0; i < 4; i++) wr(32'hA0 + i, 4'hF, i == 3);
    obs_clear();
    g = 0;
    while ((g < 2 || rd_busy || m01_axis_tvalid) && g < 100) begin
      m01_axis_tready = pat[g % 12];
      rd_req = (g == 0);
      step(1);
      g++;
    end
    rd_req = 0;
    m01_axis_tready = 1;
    chk("stall_nbeats", 64'(obs_dat.size()), 64'(4));
    for (int i = 0; i < 4 && i < obs_dat.size(); i++) begin
      chk("stall_order", 64'(obs_dat[i]), 64'(32'hA0 + i));
      chk("stall_lastpos", 64'(obs_last[i]), 64'(i == 3));
    end

    // Strobe table
    tbl[0] = '{32'hAABBCCDD, 4'b0101, 32'h00BB00DD};
    tbl[1] = '{32'h11223344, 4'b1111, 32'h11223344};
    tbl[2] = '{32'h12345678, 4'b0000, 32'h00000000};
    tbl[3] = '{32'hDEADBEEF, 4'b1000, 32'hDE000000};
    tbl[4] = '{32'hCAFEF00D, 4'b0110, 32'h00FEF000};
    tbl[5] = '{32'h0F0F0F0F, 4'b1001, 32'h0F00000F};
    for (int i = 0; i < 6; i++) wr(tbl[i].d, tbl[i].s, i == 5);
    obs_clear();
    rd_pulse();
    wait_idle();
    chk("tbl_nbeats", 64'(obs_dat.size()), 64'(6));
    for (int i = 0; i < 6 && i < obs_dat.size(); i++)
      chk("tbl_mask", 64'(obs_dat[i]), 64'(tbl[i].exp));

    // Read request while empty
    chk("err_pre_count", 64'(count), 64'(0));
    rd_pulse();
    chk("err_pulse", 64'(rd_empty_err), 64'(1));
    chk("err_no_vld", 64'(m01_axis_tvalid), 64'(0));
    step(1);
    chk("err_clear", 64'(rd_empty_err), 64'(0));
    chk("err_still_no_vld", 64'(m01_axis_tvalid), 64'(0));
    chk("err_not_busy", 64'(rd_busy), 64'(0));

    // Reset during the second beat of a 3-word readout
    for (int i = 0; i < 3; i++) wr(32'hC0 + i, 4'hF, i == 2);
    obs_clear();
    rd_pulse();
    g = 0;
    while (obs_dat.size() < 1 && g < 20) begin
      step(1);
      g++;
    end
    chk("mid_beat2_vld", 64'(m01_axis_tvalid), 64'(1));
    mon_on = 0;
    axis_areset = 1;
    step(1);
    chk("mid_vld", 64'(m01_axis_tvalid), 64'(0));
    chk("mid_last", 64'(m01_axis_tlast), 64'(0));
    chk("mid_count", 64'(count), 64'(0));
    chk("mid_busy", 64'(rd_busy), 64'(0));
    chk("mid_nbeats", 64'(obs_dat.size()), 64'(1));
    if (obs_dat.size() > 0) chk("mid_first_nolast", 64'(obs_last[0]), 64'(0));
    model_clear();
    axis_areset = 0;
    step(1);
    mon_on = 1;

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      s01_axis_tvalid = ($urandom_range(0, 1) == 1);
      s01_axis_tdata  = $urandom;
      s01_axis_tstrb  = 4'($urandom_range(0, 15));
      s01_axis_tlast  = ($urandom_range(0, 3) == 0);
      m01_axis_tready = ($urandom_range(0, 3) != 0);
      rd_req          = ($urandom_range(0, 15) == 0);
      step(1);
    end
    s01_axis_tvalid = 0; rd_req = 0; m01_axis_tready = 1;
    g = 0;
    while ((count != 0 || rd_busy) && g < 400) begin
      if (!rd_busy && count != 0) rd_pulse();
      else step(1);
      g++;
    end
    wait_idle();
    chk("drain_count", 64'(count), 64'(0));
    step(2);

    mon_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mem_responder.md
Name: stream_mem_responder

Overview:
- Memory-side endpoint for the AXI-Stream write path driven by the team's memory controller.
- Accepts byte-strobed write beats on a slave AXI-Stream port into an internal circular buffer of DEPTH words.
- On a read request, streams every stored word back out of a master AXI-Stream port as one packet, with tlast on the final beat.
- Sits between the memory controller's master port and any downstream reader or checker.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- DEPTH, 16: number of stored words; must be a power of 2, at least 2.
- ADDR_WIDTH, $clog2(DEPTH): pointer width (derived, not overridden).

Ports:
- axis_aclk  in  1  single clock for both stream ports.
- axis_areset  in  1  synchronous, active-high reset.
- s01_axis_tdata  in  DATA_WIDTH  write data.
- s01_axis_tstrb  in  DATA_WIDTH/8  byte strobes.
- s01_axis_tvalid  in  1  write beat valid.
- s01_axis_tlast  in  1  last beat of write packet.
- s01_axis_tready  out  1  write beat accepted.
- rd_req  in  1  one-cycle pulse requesting a full readout.
- m01_axis_tready  in  1  downstream ready.
- m01_axis_tdata  out  DATA_WIDTH  read data.
- m01_axis_tstrb  out  DATA_WIDTH/8  all ones while tvalid, else 0.
- m01_axis_tvalid  out  1  read beat valid.
- m01_axis_tlast  out  1  final beat of readout.
- count  out  ADDR_WIDTH+1  stored word count.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- rd_busy  out  1  readout in progress.
- rd_empty_err  out  1  one-cycle pulse: rd_req while empty.
- wr_pkts  out  8  write packets completed (tlast beats accepted); wraps 255->0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, sampled on the rising edge of axis_aclk.
- Reset values:
  - s01_axis_tready=0; all m01 outputs=0; count=0; empty=1; full=0; rd_busy=0; rd_empty_err=0; wr_pkts=0.
  - Read and write pointers=0.
  - Stored RAM contents are don't-care.
  - A reset asserted mid-readout or mid-write aborts immediately and drops tvalid the next cycle; no tlast is emitted.
- Write side:
  - s01_axis_tready=!full, registered; it goes to 1 the first cycle after reset deasserts.
  - A beat is accepted when tvalid&&tready. It writes to RAM[wr_ptr] and wr_ptr increments modulo DEPTH.
  - Byte lane i is stored as tdata[8i+7:8i] if tstrb[i]=1, else 0x00.
  - A beat with tstrb==0 is still accepted and stored as zero.
  - tlast only increments wr_pkts; it does not gate storage.
- Read FSM states: R_IDLE, R_FETCH, R_SEND.
  - R_IDLE: rd_req with count>0 snapshots n=count into a beat counter, asserts rd_busy, and goes to R_FETCH.
  - R_IDLE: rd_req with count==0 pulses rd_empty_err for 1 cycle and stays in R_IDLE.
  - R_FETCH: issues the synchronous RAM read at rd_ptr and goes to R_SEND. First m01_axis_tvalid appears 2 cycles after the rd_req cycle.
  - R_SEND:
    - A beat completes on tvalid&&tready.
    - tdata, tlast and tvalid are held stable while tready=0.
    - The next word is prefetched so that with tready held high, one beat is sent per cycle.
    - tlast=1 on beat n. After that beat completes: tvalid=0, rd_busy=0, return to R_IDLE.
  - rd_req while rd_busy is ignored, with no error pulse.
- Count and pointers:
  - Each sent beat frees its slot: rd_ptr increments modulo DEPTH and count decrements.
  - The same cycle's write acceptance and beat send change count by net 0.
  - Words written during a readout are not part of that packet (n is snapshot); they remain stored.
  - Pointer wrap DEPTH-1 -> 0 is seamless; data order is preserved across wrap.
  - full and empty are derived combinationally from count.

Decomposition:
- Shared package mem_stream_pkg:
  - read FSM enum (R_IDLE, R_FETCH, R_SEND);
  - default DATA_WIDTH constant;
  - strobe-mask function (tdata, tstrb -> masked word).
- One sub-module, stream_ram: simple dual-port synchronous RAM with one write port, one read port, 1-cycle read latency, and no reset on its contents.

Test Plan:
- Reset then release: all outputs at reset values; s01_axis_tready=1 one cycle after release; empty=1.
- Write 0x11,0x22,0x33,0x44 (tstrb=0xF, tlast on 4th), then pulse rd_req with tready=1:
  - tvalid rises 2 cycles later;
  - 4 consecutive beats 0x11..0x44, tlast only on 0x44;
  - wr_pkts=1; count=0.
- Write 16 words with DEPTH=16: full=1 and s01_axis_tready=0; a 17th beat held valid is not accepted until one word is read out.
- m01_axis_tready toggling 1,0,0,1,... during a 4-word readout: tdata and tlast stable through stalls; order and values intact; no duplicated or dropped beats.
- Write 0xAABBCCDD with tstrb=4'b0101, then read: 0x00BB00DD. rd_req with count==0: rd_empty_err pulses for 1 cycle and tvalid stays 0.
- Pulse rd_req on 3 stored words and assert axis_areset on the 2nd beat: next cycle tvalid=0, count=0, rd_busy=0; no tlast observed.
